adpcm_decoder_mc: RTL and testbench

- Multi-channel, pipelined IMA-ADPCM decoder.
- Takes one 4-bit code per cycle tagged with a channel number. Returns the reconstructed 16-bit sample.
- Keeps per-channel predictor and step-index state internally, including the step-size table and index adaptation.
- Sits between the bitstream unpacker and the sample output FIFO. Handshakes are valid/ready on both sides.

---
 rtl/adpcm_pkg.sv | 31 +++
 rtl/adpcm_step_core.sv | 36 +++
 rtl/adpcm_decoder_mc.sv | 95 +++++++++
 tb/tb_adpcm_decoder_mc.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adpcm_pkg.sv
// Shared IMA-ADPCM constants and per-channel state type (decoder and future encoder).
package adpcm_pkg;

   localparam int unsigned PRED_W  = 16;
   localparam int unsigned IDX_W   = 7;
   localparam int unsigned IDX_MAX = 88;
   localparam int          SAMPLE_MIN = -32768;
   localparam int          SAMPLE_MAX = 32767;

   // Standard 89-entry IMA step-size table
   localparam int unsigned STEP_TABLE [89] = '{
      7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
      19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
      50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
      130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
      337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
      876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
      2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
      5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
      15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
   };

   // Step-index adjustment indexed by code magnitude
   localparam int IDX_ADJ [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

   typedef struct packed {
      logic signed [PRED_W-1:0] pred;
      logic [IDX_W-1:0]         index;
   } chan_state_t;

endpackage

// File: rtl/adpcm_step_core.sv
// Combinational IMA-ADPCM state update: one nibble applied to one channel state.
module adpcm_step_core
   import adpcm_pkg::*;
(
   input  chan_state_t state,
   input  logic [3:0]  code,
   output chan_state_t next
);

   logic [16:0]        step;
   logic [16:0]        diff;
   logic signed [17:0] sum;
   logic signed [7:0]  idx_sum;

   // Difference from step shifts, saturated predictor and clamped index
   always_comb begin
      step = 17'(STEP_TABLE[state.index]);
      diff = step >> 3;
      if (code[2]) diff = diff + step;
      if (code[1]) diff = diff + (step >> 1);
      if (code[0]) diff = diff + (step >> 2);

      if (code[3]) sum = 18'(state.pred) - $signed({1'b0, diff});
      else         sum = 18'(state.pred) + $signed({1'b0, diff});

      if (sum > 18'(SAMPLE_MAX))      next.pred = 16'sh7FFF;
      else if (sum < 18'(SAMPLE_MIN)) next.pred = 16'sh8000;
      else                            next.pred = sum[15:0];

      idx_sum = $signed({1'b0, state.index}) + 8'(IDX_ADJ[code[2:0]]);
      if (idx_sum < 8'sd0)                next.index = '0;
      else if (idx_sum > 8'(IDX_MAX))     next.index = 7'(IDX_MAX);
      else                                next.index = idx_sum[6:0];
   end

endmodule

// File: rtl/adpcm_decoder_mc.sv
// Multi-channel two-stage IMA-ADPCM decoder with valid/ready on both sides.
module adpcm_decoder_mc
   import adpcm_pkg::*;
#(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned SAMPLE_W = PRED_W,
   localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CH_W-1:0]            in_ch,
   input  logic [3:0]                 in_code,
   input  logic                       init_valid,
   input  logic [CH_W-1:0]            init_ch,
   input  logic signed [SAMPLE_W-1:0] init_pred,
   input  logic [6:0]                 init_index,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CH_W-1:0]            out_ch,
   output logic signed [SAMPLE_W-1:0] out_sample
);

   chan_state_t      st_q [CHANNELS];
   logic             s1_valid;
   logic [CH_W-1:0]  s1_ch;
   logic [3:0]       s1_code;
   logic             out_adv;
   logic             s1_adv;
   logic             ch_ok;
   chan_state_t      cur_state;
   chan_state_t      nxt_state;
   chan_state_t      init_state;

   assign out_adv  = ~out_valid | out_ready;
   assign s1_adv   = s1_valid & out_adv;
   assign in_ready = (~s1_valid | out_adv) & ~init_valid;
   assign ch_ok    = 32'(s1_ch) < CHANNELS;
   assign cur_state = ch_ok ? st_q[s1_ch] : '0;

   assign init_state.pred  = init_pred;
   assign init_state.index = (init_index > 7'(IDX_MAX)) ? 7'(IDX_MAX) : init_index;

   adpcm_step_core u_core (
      .state (cur_state),
      .code  (s1_code),
      .next  (nxt_state)
   );

   // Channel state: header load takes priority over the S1 writeback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(CHANNELS); i++) st_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(CHANNELS); i++) begin
            if (init_valid && int'(init_ch) == i)
               st_q[i] <= init_state;
            else if (s1_adv && ch_ok && int'(s1_ch) == i)
               st_q[i] <= nxt_state;
         end
      end
   end

   // Stage 1: capture accepted code and channel tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_ch    <= '0;
         s1_code  <= '0;
      end else if (!s1_valid || out_adv) begin
         s1_valid <= in_valid & in_ready;
         if (in_valid && in_ready) begin
            s1_ch   <= in_ch;
            s1_code <= in_code;
         end
      end
   end

   // Output stage: register decoded sample, hold while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_ch     <= '0;
         out_sample <= '0;
      end else if (out_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_ch     <= s1_ch;
            out_sample <= ch_ok ? nxt_state.pred : '0;
         end
      end
   end

endmodule

// File: tb/tb_adpcm_decoder_mc.sv
// Scoreboard bench for adpcm_decoder_mc: directed spec cases plus randomized traffic.
module tb_adpcm_decoder_mc;

   localparam int NCH = 3;

   localparam int STEP_TAB [89] = '{
      7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
      19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
      50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
      130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
      337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
      876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
      2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
      5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
      15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
   };

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [1:0]         in_ch = '0;
   logic [3:0]         in_code = '0;
   logic               init_valid = 1'b0;
   logic [1:0]         init_ch = '0;
   logic signed [15:0] init_pred = '0;
   logic [6:0]         init_index = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [1:0]         out_ch;
   logic signed [15:0] out_sample;

   typedef struct { int ch; int s; } exp_t;
   exp_t sbq [$];

   int m_pred [4];
   int m_idx  [4];
   int tests = 0;
   int fails = 0;

   adpcm_decoder_mc #(.CHANNELS(NCH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ch      (in_ch),
      .in_code    (in_code),
      .init_valid (init_valid),
      .init_ch    (init_ch),
      .init_pred  (init_pred),
      .init_index (init_index),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ch     (out_ch),
      .out_sample (out_sample)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // Reference IMA decode of one nibble on the model state
   function automatic int model_decode(int ch, int code);
      int step, diff, p, mag, x;
      step = STEP_TAB[m_idx[ch]];
      diff = step / 8;
      if ((code & 4) != 0) diff += step;
      if ((code & 2) != 0) diff += step / 2;
      if ((code & 1) != 0) diff += step / 4;
      p = ((code & 8) != 0) ? m_pred[ch] - diff : m_pred[ch] + diff;
      if (p > 32767) p = 32767;
      if (p < -32768) p = -32768;
      mag = code & 7;
      x = m_idx[ch] + ((mag < 4) ? -1 : 2 * (mag - 3));
      if (x < 0) x = 0;
      if (x > 88) x = 88;
      m_pred[ch] = p;
      m_idx[ch] = x;
      return p;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_pred[i] = 0;
         m_idx[i] = 0;
      end
   endfunction

   task automatic drive(input bit v, input int ch, input int code, input bit ordy,
                        input bit has_exp, input int expv, output bit acc);
      int s;
      exp_t e;
      @(negedge clk);
      in_valid = v;
      in_ch = 2'(ch);
      in_code = 4'(code);
      out_ready = ordy;
      init_valid = 1'b0;
      #1;
      acc = v && in_ready;
      if (acc) begin
         s = (ch < NCH) ? model_decode(ch, code) : 0;
         e.ch = ch;
         e.s = has_exp ? expv : s;
         sbq.push_back(e);
      end
   endtask

   task automatic send(input int ch, input int code, input bit has_exp, input int expv);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 20) begin
         drive(1'b1, ch, code, 1'b1, has_exp, expv, acc);
         n++;
      end
      if (!acc) begin
         tests++;
         fails++;
         $display("FAIL send_accept: ch %0d code %0d not accepted in 20 cycles", ch, code);
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b1, 1'b0, 0, acc);
   endtask

   task automatic do_init(input int ch, input int p, input int idx);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      init_valid = 1'b1;
      init_ch = 2'(ch);
      init_pred = 16'(p);
      init_index = 7'(idx);
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL init_ready: in_ready=%b required 0", in_ready);
      end
      m_pred[ch] = p;
      m_idx[ch] = (idx > 88) ? 88 : idx;
   endtask

   // Monitor: pop and compare on every output handshake, check stall holding
   initial begin : monitor
      bit held;
      logic [1:0] hch;
      logic signed [15:0] hs;
      exp_t e;
      held = 1'b0;
      hch = '0;
      hs = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               tests++;
               if (out_valid !== 1'b1 || out_ch !== hch || out_sample !== hs) begin
                  fails++;
                  $display("FAIL hold: v=%b ch=%0d s=%0d required v=1 ch=%0d s=%0d",
                           out_valid, out_ch, out_sample, hch, hs);
               end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
               tests++;
               if (sbq.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_out: ch=%0d s=%0d with empty scoreboard", out_ch, out_sample);
               end else begin
                  e = sbq.pop_front();
                  if (int'(out_ch) != e.ch || int'(out_sample) != e.s) begin
                     fails++;
                     $display("FAIL sample: got ch=%0d s=%0d required ch=%0d s=%0d",
                              out_ch, out_sample, e.ch, e.s);
                  end
               end
            end
            held = out_valid && !out_ready;
            hch = out_ch;
            hs = out_sample;
         end
      end
   end

   initial begin : stim
      bit acc;
      int acc_cnt;
      model_reset();

      #3;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sample !== 16'sd0 || out_ch !== 2'd0) begin
         fails++;
         $display("FAIL reset: v=%b rdy=%b s=%0d ch=%0d required 0 1 0 0",
                  out_valid, in_ready, out_sample, out_ch);
      end
      #9 rst_n = 1'b1;

      // Basic decode and back-to-back same channel
      send(0, 4'b0111, 1'b1, 11);
      send(0, 4'b1111, 1'b1, -19);
      // Index floor on untouched channel
      send(2, 4'b0000, 1'b1, 0);
      send(2, 4'b0111, 1'b1, 11);
      // Saturation
      do_init(1, 32760, 88);
      send(1, 4'b0111, 1'b1, 32767);
      send(1, 4'b1111, 1'b1, -28669);
      do_init(1, -32760, 88);
      send(1, 4'b1111, 1'b1, -32768);
      // Init index clamp
      do_init(1, 0, 120);
      send(1, 4'b0000, 1'b1, 4095);
      // Out-of-range channel
      send(3, 4'b0111, 1'b1, 0);
      // Init coinciding with S1 writeback on the same channel
      send(0, 4'b0001, 1'b1, -7);
      do_init(0, 1000, 10);
      send(0, 4'b0000, 1'b1, 1002);
      // Interleaved back-to-back
      send(0, 4'b0101, 1'b0, 0);
      send(0, 4'b1010, 1'b0, 0);
      send(1, 4'b0011, 1'b0, 0);
      send(0, 4'b1100, 1'b0, 0);
      idle(4);

      // Backpressure: only two codes fit while sink stalls
      acc_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, int'($urandom % 2), int'($urandom % 16), 1'b0, 1'b0, 0, acc);
         acc_cnt += int'(acc);
      end
      tests++;
      if (acc_cnt != 2) begin
         fails++;
         $display("FAIL stall_accepts: accepted %0d required 2", acc_cnt);
      end
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL stall_ready: in_ready=%b required 0", in_ready);
      end
      idle(4);

      // Random traffic with random backpressure
      for (int i = 0; i < 300; i++)
         drive(($urandom % 4) != 0, int'($urandom % 4), int'($urandom % 16),
               ($urandom % 4) != 0, 1'b0, 0, acc);

      // Asynchronous reset mid-stream
      @(negedge clk);
      #3;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL midreset: v=%b rdy=%b required 0 1", out_valid, in_ready);
      end
      sbq.delete();
      model_reset();
      @(negedge clk);
      #3 rst_n = 1'b1;

      send(0, 4'b0111, 1'b1, 11);
      for (int i = 0; i < 300; i++)
         drive(($urandom % 3) != 0, int'($urandom % 4), int'($urandom % 16),
               ($urandom % 3) != 0, 1'b0, 0, acc);

      // Drain
      for (int i = 0; i < 100 && sbq.size() > 0; i++) idle(1);
      tests++;
      if (sbq.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d samples outstanding, required 0", sbq.size());
      end
      idle(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
